// File: rtl/divide_n.sv
// divide_n: sequential unsigned integer divider using restoring shift-subtract,
// producing one quotient bit per clock.
//
// Ports:
//   clk_i          system clock; all state changes on its rising edge
//   rst_i          asynchronous active-high reset
//   start_i        request a division; accepted in IDLE or DONE
//   dividend_i     unsigned dividend (WIDTH bits), sampled with start_i
//   divisor_i      unsigned divisor (DWIDTH bits), sampled with start_i
//   quotient_o     registered quotient; holds the last completed result
//   remainder_o    registered remainder; holds the last completed result
//   ready_o        level: quotient_o/remainder_o hold a completed result
//   busy_o         high while a division is in progress
//   div_by_zero_o  high with ready_o when the last divisor was zero
//
// State table:
//   IDLE | no result yet since reset
//   RUN  | division in progress, one quotient bit per clock
//   DONE | result valid on outputs, held until the next accepted start
module divide_n #(
  parameter int WIDTH  = 14,
  parameter int DWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  dividend_i,
  input  logic [DWIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0]  quotient_o,
  output logic [DWIDTH-1:0] remainder_o,
  output logic              ready_o,
  output logic              busy_o,
  output logic              div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [DWIDTH-1:0] dvs_q, dvs_d;
  logic [DWIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  quotient_q, quotient_d;
  logic [DWIDTH-1:0] remainder_q, remainder_d;
  logic              ready_q, ready_d;
  logic              dbz_q, dbz_d;

  logic [DWIDTH:0]   shifted;
  logic              fits;
  logic [DWIDTH:0]   prem_next;
  logic [WIDTH-1:0]  quo_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ready_q     <= ready_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ready_d     = ready_q;
    dbz_d       = dbz_q;

    // The partial remainder is always < divisor before the shift, so its top
    // bit is zero and the shift into DWIDTH+1 bits cannot lose information.
    shifted   = (prem_q << 1) | (DWIDTH + 1)'(dvd_q[WIDTH-1]);
    fits      = (shifted >= {1'b0, dvs_q});
    prem_next = fits ? (shifted - {1'b0, dvs_q}) : shifted;
    quo_next  = (quo_q << 1) | WIDTH'(fits);

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          dvd_d   = dividend_i;
          dvs_d   = divisor_i;
          prem_d  = '0;
          quo_d   = '0;
          cnt_d   = CNT_INIT;
          ready_d = 1'b0;
          dbz_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (dvs_q == '0) begin
          // Zero divisor finishes after one RUN cycle with a saturated quotient.
          quotient_d  = '1;
          remainder_d = '0;
          dbz_d       = 1'b1;
          ready_d     = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          dvd_d  = dvd_q << 1;
          prem_d = prem_next;
          quo_d  = quo_next;
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quotient_d  = quo_next;
            remainder_d = prem_next[DWIDTH-1:0];
            ready_d     = 1'b1;
            state_d     = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign ready_o       = ready_q;
  assign busy_o        = (state_q == RUN);
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_divide_n.sv
module tb_divide_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default-parameter instance (WIDTH=14, DWIDTH=4)
  logic        start_a;
  logic [13:0] dvd_a;
  logic [3:0]  dvs_a;
  logic [13:0] quo_a;
  logic [3:0]  rem_a;
  logic        ready_a, busy_a, dbz_a;

  // WIDTH=8, DWIDTH=8 instance
  logic        start_b;
  logic [7:0]  dvd_b;
  logic [7:0]  dvs_b;
  logic [7:0]  quo_b;
  logic [7:0]  rem_b;
  logic        ready_b, busy_b, dbz_b;

  divide_n dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a),
    .dividend_i(dvd_a), .divisor_i(dvs_a),
    .quotient_o(quo_a), .remainder_o(rem_a),
    .ready_o(ready_a), .busy_o(busy_a), .div_by_zero_o(dbz_a)
  );

  divide_n #(.WIDTH(8), .DWIDTH(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b),
    .dividend_i(dvd_b), .divisor_i(dvs_b),
    .quotient_o(quo_b), .remainder_o(rem_b),
    .ready_o(ready_b), .busy_o(busy_b), .div_by_zero_o(dbz_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [13:0] q;
    logic [13:0] r;
    logic        dbz;
    int          at;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int total = 0;
  int bad   = 0;

  logic [13:0] hold_a = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor A: compares each completed result against the scoreboard and
  // checks that outputs hold while busy and that busy/ready never overlap.
  logic rdy_prev_a = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (busy_a && ready_a) chk("a_busy_ready_overlap", 1, 0);
      if (busy_a) chk("a_hold_quotient", 32'(quo_a), 32'(hold_a));
      if (ready_a && !rdy_prev_a) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_ready", 1, 0);
        end else begin
          exp_t e;
          e = qa.pop_front();
          chk("a_quotient", 32'(quo_a), 32'(e.q));
          chk("a_remainder", 32'(rem_a), 32'(e.r));
          chk("a_div_by_zero", 32'(dbz_a), 32'(e.dbz));
          chk("a_latency_cycle", 32'(cyc), 32'(e.at));
          hold_a = e.q;
        end
      end
    end
    rdy_prev_a = ready_a;
  end

  logic rdy_prev_b = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (busy_b && ready_b) chk("b_busy_ready_overlap", 1, 0);
      if (ready_b && !rdy_prev_b) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_ready", 1, 0);
        end else begin
          exp_t e;
          e = qb.pop_front();
          chk("b_quotient", 32'(quo_b), 32'(e.q));
          chk("b_remainder", 32'(rem_b), 32'(e.r));
          chk("b_div_by_zero", 32'(dbz_b), 32'(e.dbz));
          chk("b_latency_cycle", 32'(cyc), 32'(e.at));
        end
      end
    end
    rdy_prev_b = ready_b;
  end

  // Called at a negedge; returns at the first negedge with ready_a high.
  task automatic wait_ready_a(input string name);
    int n = 0;
    while (!ready_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready_a) chk(name, 0, 1);
  endtask

  // Issue one start on A, queue the expected result, check the start took.
  task automatic run_op(input logic [13:0] dd, input logic [3:0] ds,
                        input logic [13:0] eq, input logic [13:0] er,
                        input logic edbz, input int lat);
    exp_t e;
    @(negedge clk);
    start_a = 1'b1; dvd_a = dd; dvs_a = ds;
    e.q = eq; e.r = er; e.dbz = edbz; e.at = cyc + 1 + lat;
    qa.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy_after_start", 32'(busy_a), 1);
    chk("a_ready_after_start", 32'(ready_a), 0);
    chk("a_dbz_after_start", 32'(dbz_a), 0);
    wait_ready_a("a_ready_timeout");
  endtask

  initial begin
    exp_t e;
    int n;
    rst = 1'b1;
    start_a = 1'b0; dvd_a = '0; dvs_a = '0;
    start_b = 1'b0; dvd_b = '0; dvs_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_quotient", 32'(quo_a), 0);
    chk("rst_remainder", 32'(rem_a), 0);
    chk("rst_ready", 32'(ready_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_dbz", 32'(dbz_a), 0);

    run_op(14'd1024, 4'd10, 14'd102, 14'd4, 1'b0, 14);
    run_op(14'd16383, 4'd1, 14'd16383, 14'd0, 1'b0, 14);
    run_op(14'd5, 4'd9, 14'd0, 14'd5, 1'b0, 14);
    run_op(14'd1234, 4'd0, 14'd16383, 14'd0, 1'b1, 1);
    chk("dbz_busy_low", 32'(busy_a), 0);

    // Start ignored while busy, then back-to-back start at the ready edge.
    @(negedge clk);
    start_a = 1'b1; dvd_a = 14'd1024; dvs_a = 4'd10;
    e.q = 14'd102; e.r = 14'd4; e.dbz = 1'b0; e.at = cyc + 1 + 14;
    qa.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    start_a = 1'b1; dvd_a = 14'd999; dvs_a = 4'd7;
    @(negedge clk);
    start_a = 1'b0; dvd_a = 14'd3; dvs_a = 4'd2;
    wait_ready_a("ign_ready_timeout");
    start_a = 1'b1; dvd_a = 14'd999; dvs_a = 4'd7;
    e.q = 14'd142; e.r = 14'd5; e.dbz = 1'b0; e.at = cyc + 1 + 14;
    qa.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    chk("b2b_ready_dropped", 32'(ready_a), 0);
    chk("b2b_busy", 32'(busy_a), 1);
    chk("b2b_quotient_held", 32'(quo_a), 102);
    wait_ready_a("b2b_ready_timeout");

    // Asynchronous reset in the middle of a RUN.
    @(negedge clk);
    start_a = 1'b1; dvd_a = 14'd1024; dvs_a = 4'd10;
    @(negedge clk);
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_quotient", 32'(quo_a), 0);
    chk("midrst_remainder", 32'(rem_a), 0);
    chk("midrst_busy", 32'(busy_a), 0);
    chk("midrst_ready", 32'(ready_a), 0);
    chk("midrst_dbz", 32'(dbz_a), 0);
    hold_a = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(14'd255, 4'd15, 14'd17, 14'd0, 1'b0, 14);

    // 8-bit instance: divisor larger than dividend.
    @(negedge clk);
    start_b = 1'b1; dvd_b = 8'd200; dvs_b = 8'd201;
    e.q = 14'd0; e.r = 14'd200; e.dbz = 1'b0; e.at = cyc + 1 + 8;
    qb.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    chk("b_busy_after_start", 32'(busy_b), 1);

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(qa.size() + qb.size()), 0);
    repeat (3) @(negedge clk);
    chk("b_ready_held", 32'(ready_b), 1);
    chk("a_ready_held", 32'(ready_a), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
